keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4096: clock cycles each row is driven before the next row is selected.
REQ-002 Parameter DEBOUNCE_CYCLES, default 240000: consecutive stable cycles required for press or release acceptance.
REQ-003 Parameter REPEAT_CYCLES, default 12000000: auto-repeat interval; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 col  input  4  raw keypad columns, asynchronous, pulled up; a pressed key reads 0.
REQ-007 r_sel  output  4  row drive, active-low, exactly one bit low at all times.
REQ-008 key_code  output  4  hex code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle strobe per accepted key.
REQ-010 right  output  4  newest digit, for the display-mux stage.
REQ-011 left  output  4  previous digit, for the display-mux stage.

Function
REQ-012 col passes through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-013 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: r_sel rotates 1110->1101->1011->0111->1110; each pattern is held for SCAN_DIV cycles.
REQ-015 SCAN: on the last dwell cycle of a row, if any col_s bit is 0, lock that row and the lowest-index low column, then go to DEBOUNCE with the counter cleared and r_sel frozen.
REQ-016 DEBOUNCE: the locked col_s bit must stay 0 for DEBOUNCE_CYCLES consecutive cycles, then the FSM goes to HELD.
REQ-017 DEBOUNCE: if the locked bit reads 1 first, return to SCAN at the next row with no strobe.
REQ-018 On the DEBOUNCE->HELD transition, in the same clock edge: key_valid=1 for one cycle, key_code=map(row,col), left<=right, right<=new code.
REQ-019 Key map (row0..3 x col0..3): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-020 HELD: other columns and rows are ignored; when the locked bit reads 1, go to RELEASE with the counter cleared.
REQ-021 RELEASE: locked bit high for DEBOUNCE_CYCLES consecutive cycles -> SCAN at the next row; any 0 before that -> HELD with no strobe.
REQ-022 The same key pressed twice in succession produces two strobes and shifts twice.
REQ-023 Latency: first synchronized low sample to key_valid = DEBOUNCE_CYCLES+1 cycles.
REQ-024 Counters are sized with $clog2 of the largest parameter and never wrap inside a state.

Reset
REQ-025 reset low: state=SCAN, r_sel=1110, key_code=0, key_valid=0, left=0, right=0, counters=0, synchronizer flops=1111.
REQ-026 Reset mid-operation (any state) aborts it immediately; no strobe is emitted while reset is held or on release of reset.

Configuration
REQ-027 KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_CYCLES continuous hold, behave as REQ-018 again (strobe and shift), then re-arm every REPEAT_CYCLES.
REQ-028 KEYPAD_REPEAT_EN undefined: exactly one strobe per press; no repeat counter is synthesized.

Structure
REQ-029 keypad_pkg holds the state enum, the 16-entry key map constant, and the row reset pattern 4'b1110.
REQ-030 One sub-module, keypad_col_sync: 2-flop synchronizer for col with reset value 1111.

Verification
Benches use SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20.
REQ-031 Reset asserted mid-DEBOUNCE -> r_sel=1110, outputs zero, no key_valid afterward until a new full press.
REQ-032 Hold col=1101 while r_sel=1101 for 30 cycles -> one key_valid, key_code=5, right=5, left=0.
REQ-033 Press 5, release, then press 0 (row3, col1) -> right=0, left=5, two strobes total.
REQ-034 Press glitch of 3 cycles (col0 low during row0) -> no strobe, scanning resumes at row1.
REQ-035 Release bounce of 4 cycles high, then low again, then a clean release -> no second strobe, FSM reaches SCAN.
REQ-036 KEYPAD_REPEAT_EN defined, hold key A for 70 cycles after acceptance -> three extra strobes 20 cycles apart, with right and left both holding A after the first repeat.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// row drive pattern, key code map and column priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Indexed by {row, col}; entry 0 is row0/col0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] row_pattern(input logic [1:0] row);
    return ~(~ROW_RESET << row);
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and display-side signals of the scanner, bundled for port lists.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] r_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] right;
  logic [3:0] left;

  modport master (input col, output r_sel, key_code, key_valid, right, left);
  modport slave  (output col, input r_sel, key_code, key_valid, right, left);
endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the raw, pulled-up keypad columns.
module keypad_col_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_i,
  output logic [3:0] col_s_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // NOTE: asynchronous active-low reset; idle (released) columns read 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  assign col_s_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and a two-digit shift register.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_CYCLES   = 12000000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);
  import keypad_pkg::*;

`ifdef KEYPAD_REPEAT_EN
  localparam int CNT_MAX_SD = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_SD > REPEAT_CYCLES) ? CNT_MAX_SD : REPEAT_CYCLES;
`else
  localparam int CNT_MAX    = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // The synchronizer delay has to fit inside one row dwell for a key to be seen.
  if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: need SCAN_DIV >= 3, DEBOUNCE_CYCLES >= 1, REPEAT_CYCLES >= 1");
  end

  logic [3:0]       col_s;
  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       r_sel_q, r_sel_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       right_q, right_d;
  logic [3:0]       left_q, left_d;
  logic             locked_low;
  logic             accept;

  keypad_col_sync u_col_sync (
    .clk     (clk),
    .reset   (reset),
    .col_i   (kp.col),
    .col_s_o (col_s)
  );

  assign locked_low = ~col_s[col_idx_q];

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (col_s != 4'b1111) begin
            col_idx_d = first_low(col_s);
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!locked_low) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!locked_low) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (cnt_q == REP_LAST) begin
          accept = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (locked_low) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase

    r_sel_d     = row_pattern(row_d);
    key_valid_d = accept;
    key_code_d  = accept ? KEY_MAP[{row_q, col_idx_q}] : key_code_q;
    right_d     = accept ? KEY_MAP[{row_q, col_idx_q}] : right_q;
    left_d      = accept ? right_q : left_q;
  end

  // NOTE: state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_q       <= '0;
      col_idx_q   <= '0;
      cnt_q       <= '0;
      r_sel_q     <= ROW_RESET;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      right_q     <= '0;
      left_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      r_sel_q     <= r_sel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      right_q     <= right_d;
      left_q      <= left_d;
    end
  end

  assign kp.r_sel     = r_sel_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.right     = right_q;
  assign kp.left      = left_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model answers the row drive,
// a vector table covers the key map and digit shift, and hand sequences
// cover latency, reset, glitches, release bounce and (KEYPAD_REPEAT_EN) repeat.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  // Keypad model: a pressed key pulls its column low only while its row is driven.
  logic       press_en = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_col = 4'hF;

  always_comb begin
    if (ovr_en)
      kp.col = ovr_col;
    else if (press_en && !kp.r_sel[press_row])
      kp.col = ~(4'b0001 << press_col);
    else
      kp.col = 4'hF;
  end

  int strobes = 0;
  always @(posedge clk) if (kp.key_valid === 1'b1) strobes <= strobes + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    ovr_en   = 1'b0;
    press_en = 1'b0;
    step(3);
    reset = 1'b1;
  endtask

  task automatic wait_strobe(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (kp.key_valid === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[9];
  int   s0;
  int   cyc;
  logic [3:0] exp_rsel;
  logic [3:0] seen;
  int   bad_onehot;

  initial begin
    vecs[0] = '{2'd1, 2'd1, 4'h5};
    vecs[1] = '{2'd3, 2'd1, 4'h0};
    vecs[2] = '{2'd0, 2'd3, 4'hA};
    vecs[3] = '{2'd3, 2'd0, 4'hE};
    vecs[4] = '{2'd2, 2'd2, 4'h9};
    vecs[5] = '{2'd3, 2'd3, 4'hD};
    vecs[6] = '{2'd3, 2'd2, 4'hF};
    vecs[7] = '{2'd1, 2'd1, 4'h5};
    vecs[8] = '{2'd1, 2'd1, 4'h5};

    // Reset state.
    step(2);
    check("reset r_sel", 32'(kp.r_sel), 32'hE);
    check("reset key_code", 32'(kp.key_code), 32'h0);
    check("reset key_valid", 32'(kp.key_valid), 32'h0);
    check("reset right", 32'(kp.right), 32'h0);
    check("reset left", 32'(kp.left), 32'h0);
    reset = 1'b1;

    // Row rotation: each pattern dwells SCAN_DIV cycles.
    for (int k = 1; k <= 17; k++) begin
      step(1);
      if (k % 4 == 1) begin
        exp_rsel = ~(4'b0001 << ((k / 4) % 4));
        check($sformatf("rotate r_sel k=%0d", k), 32'(kp.r_sel), 32'(exp_rsel));
      end
    end

    // Latency: column goes low so its first synchronized sample lands on row0's last dwell cycle.
    do_reset();
    step(1);
    ovr_col = 4'b1110;
    ovr_en  = 1'b1;
    step(10);
    check("latency no early strobe", 32'(kp.key_valid), 32'h0);
    step(1);
    check("latency strobe", 32'(kp.key_valid), 32'h1);
    check("latency key_code", 32'(kp.key_code), 32'h1);
    check("latency right", 32'(kp.right), 32'h1);
    check("latency left", 32'(kp.left), 32'h0);
    step(1);
    check("strobe one cycle", 32'(kp.key_valid), 32'h0);
    check("held r_sel frozen", 32'(kp.r_sel), 32'hE);
    ovr_col = 4'hF;
    step(16);

    // Reset mid-DEBOUNCE: 8 cycles after pulling col0 low it is locked but not yet accepted.
    s0 = strobes;
    ovr_col = 4'b1110;
    step(8);
    reset = 1'b0;
    #1;
    check("rst mid r_sel", 32'(kp.r_sel), 32'hE);
    check("rst mid key_code", 32'(kp.key_code), 32'h0);
    check("rst mid right", 32'(kp.right), 32'h0);
    check("rst mid left", 32'(kp.left), 32'h0);
    check("rst mid key_valid", 32'(kp.key_valid), 32'h0);
    step(5);
    ovr_col = 4'hF;
    reset = 1'b1;
    step(40);
    check("rst mid no strobe", 32'(strobes - s0), 32'h0);

    // Press glitch of 3 cycles on row0/col0.
    do_reset();
    s0 = strobes;
    step(1);
    ovr_col = 4'b1110;
    ovr_en  = 1'b1;
    step(3);
    ovr_col = 4'hF;
    step(2);
    check("glitch r_sel frozen", 32'(kp.r_sel), 32'hE);
    step(1);
    check("glitch resumes row1", 32'(kp.r_sel), 32'hD);
    step(20);
    check("glitch no strobe", 32'(strobes - s0), 32'h0);

    // Vector table: key map, digit shift, repeated identical key.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      s0 = strobes;
      press_row = vecs[i].row;
      press_col = vecs[i].col;
      press_en  = 1'b1;
      wait_strobe(30, cyc);
      check($sformatf("vec%0d strobe seen", i), 32'(cyc != -1), 32'h1);
      check($sformatf("vec%0d key_code", i), 32'(kp.key_code), 32'(vecs[i].code));
      check($sformatf("vec%0d right", i), 32'(kp.right), 32'(vecs[i].code));
      check($sformatf("vec%0d left", i), 32'(kp.left), (i == 0) ? 32'h0 : 32'(vecs[i-1].code));
`ifndef KEYPAD_REPEAT_EN
      if (cyc > 0 && cyc < 30) step(30 - cyc);
`endif
      press_en = 1'b0;
      step(16);
      check($sformatf("vec%0d one strobe", i), 32'(strobes - s0), 32'h1);
    end

    // Release bounce: 4 cycles high, low again, then a clean release.
    s0 = strobes;
    press_row = 2'd1;
    press_col = 2'd1;
    press_en  = 1'b1;
    wait_strobe(30, cyc);
    check("bounce strobe seen", 32'(cyc != -1), 32'h1);
    step(5);
    press_en = 1'b0;
    step(4);
    press_en = 1'b1;
    step(6);
    press_en = 1'b0;
    step(16);
    check("bounce one strobe", 32'(strobes - s0), 32'h1);
    seen = 4'h0;
    bad_onehot = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      seen |= ~kp.r_sel;
      if ($countones(~kp.r_sel) != 1) bad_onehot++;
    end
    check("bounce scan all rows", 32'(seen), 32'hF);
    check("r_sel one low", 32'(bad_onehot), 32'h0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: hold key A for 70 cycles after acceptance.
    begin
      int times[3];
      int n_rep;
      n_rep = 0;
      press_row = 2'd0;
      press_col = 2'd3;
      press_en  = 1'b1;
      wait_strobe(30, cyc);
      check("repeat first strobe", 32'(cyc != -1), 32'h1);
      for (int k = 1; k <= 70; k++) begin
        step(1);
        if (kp.key_valid === 1'b1) begin
          if (n_rep < 3) times[n_rep] = k;
          n_rep++;
          if (n_rep == 1) begin
            check("repeat right", 32'(kp.right), 32'hA);
            check("repeat left", 32'(kp.left), 32'hA);
          end
        end
      end
      check("repeat count", 32'(n_rep), 32'h3);
      if (n_rep >= 3) begin
        check("repeat t0", 32'(times[0]), 32'd20);
        check("repeat t1", 32'(times[1] - times[0]), 32'd20);
        check("repeat t2", 32'(times[2] - times[1]), 32'd20);
      end
      press_en = 1'b0;
      step(16);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
